// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the systolic-array control host: register map,
// CTRL/STATUS bit positions, result codes and FSM encodings.
package sys_ctrl_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_STREAM = 4'h8;
  localparam logic [3:0] REG_FLUSH  = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int STATUS_DONE = 0;
  localparam int STATUS_BUSY = 1;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BRESP   = 2'd1;
  localparam logic [1:0] ERR_RRESP   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RESP
  } host_state_e;

  typedef enum logic [2:0] {
    P_IDLE,
    P_WR,
    P_WR_B,
    P_RD_AR,
    P_RD_R
  } port_state_e;

  function automatic logic [31:0] ctrl_word(input logic start, input logic clear);
    ctrl_word = '0;
    ctrl_word[CTRL_START] = start;
    ctrl_word[CTRL_CLEAR] = clear;
  endfunction

endpackage

// File: rtl/sys_ctrl_host_axil_master_port.sv
// Single-transaction AXI4-Lite engine: one write (AW/W/B) or one read (AR/R)
// per req pulse, finishing with a one-cycle done pulse carrying resp/rdata.
module axil_master_port
  import sys_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        resp,
  output logic [2:0]        dbg_state,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  // Handshakes: a beat transfers on the rising edge where valid & ready are both
  // high; a raised valid and its payload stay put until that edge, and the
  // valid drops on the following cycle. ready never depends on our own valid.
  port_state_e state_q, state_d;
  logic        aw_ok, w_ok;

  assign aw_ok = !m_axi_awvalid || m_axi_awready;
  assign w_ok  = !m_axi_wvalid || m_axi_wready;

  assign m_axi_bready  = (state_q == P_WR_B);
  assign m_axi_arvalid = (state_q == P_RD_AR);
  assign m_axi_rready  = (state_q == P_RD_R);
  assign dbg_state     = state_q;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= P_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      P_IDLE:  if (req) state_d = we ? P_WR : P_RD_AR;
      P_WR:    if (aw_ok && w_ok) state_d = P_WR_B;
      P_WR_B:  if (m_axi_bvalid) state_d = P_IDLE;
      P_RD_AR: if (m_axi_arready) state_d = P_RD_R;
      P_RD_R:  if (m_axi_rvalid) state_d = P_IDLE;
      default: state_d = P_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_araddr  <= '0;
      done          <= 1'b0;
      rdata         <= '0;
      resp          <= AXI_OKAY;
    end else begin
      done <= 1'b0;
      case (state_q)
        P_IDLE: begin
          if (req && we) begin
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            m_axi_awaddr  <= addr;
            m_axi_wdata   <= wdata;
          end else if (req) begin
            m_axi_araddr <= addr;
          end
        end
        P_WR: begin
          // AW and W retire independently; B is awaited only after both.
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
        end
        P_WR_B: begin
          if (m_axi_bvalid) begin
            done <= 1'b1;
            resp <= m_axi_bresp;
          end
        end
        P_RD_R: begin
          if (m_axi_rvalid) begin
            done  <= 1'b1;
            rdata <= m_axi_rdata;
            resp  <= m_axi_rresp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sys_ctrl_host.sv
// On-chip host for the systolic-array control slave: programs lengths, pulses
// START, polls STATUS until DONE and returns one result beat.
module sys_ctrl_host
  import sys_ctrl_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int POLL_MAX           = 1024
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [15:0]                     cmd_stream_len,
  input  logic [15:0]                     cmd_flush_len,
  input  logic                            cmd_clear,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [1:0]                      rsp_err,
  output logic [15:0]                     rsp_polls,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int          AW         = C_M_AXI_ADDR_WIDTH;
  localparam int          DW         = C_M_AXI_DATA_WIDTH;
  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

  host_state_e state_q, state_d;
  logic [1:0]  step_q;
  logic [15:0] stream_q, flush_q, polls_q;
  logic        clear_q;
  logic [1:0]  err_q;

  logic          port_req, port_we, port_done;
  logic [AW-1:0] port_addr, wr_addr;
  logic [DW-1:0] port_wdata, wr_data, port_rdata;
  logic [1:0]    port_resp;
  logic [2:0]    dbg_port_state;
  logic          port_err, status_done, poll_exhausted, unused_sigs;

  assign port_err       = (port_resp != AXI_OKAY);
  assign status_done    = port_rdata[STATUS_DONE];
  assign poll_exhausted = (polls_q >= POLL_LIMIT);
  assign unused_sigs    = ^{port_rdata[DW-1:1], dbg_port_state};

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_err     = err_q;
  assign rsp_polls   = polls_q;
  assign m_axi_wstrb = '1;

  // Write sequence: lengths first, then START with optional CLEAR, then a
  // zero write so the slave's START edge detector is re-armed.
  always_comb begin
    wr_addr = AW'(REG_CTRL);
    wr_data = '0;
    case (step_q)
      2'd0: begin wr_addr = AW'(REG_STREAM); wr_data = DW'(stream_q); end
      2'd1: begin wr_addr = AW'(REG_FLUSH);  wr_data = DW'(flush_q); end
      2'd2: begin wr_addr = AW'(REG_CTRL);   wr_data = DW'(ctrl_word(1'b1, clear_q)); end
      default: begin wr_addr = AW'(REG_CTRL); wr_data = DW'(ctrl_word(1'b0, 1'b0)); end
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    port_req   = 1'b0;
    port_we    = 1'b0;
    port_addr  = wr_addr;
    port_wdata = wr_data;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_WR_REQ;
      ST_WR_REQ: begin
        port_req = 1'b1;
        port_we  = 1'b1;
        state_d  = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (port_done) begin
          if (port_err)           state_d = ST_RESP;
          else if (step_q == 2'd3) state_d = ST_RD_REQ;
          else                     state_d = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        port_req  = 1'b1;
        port_addr = AW'(REG_STATUS);
        state_d   = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (port_done) begin
          if (port_err || status_done || poll_exhausted) state_d = ST_RESP;
          else                                           state_d = ST_RD_REQ;
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      step_q   <= 2'd0;
      stream_q <= '0;
      flush_q  <= '0;
      clear_q  <= 1'b0;
      err_q    <= ERR_OK;
      polls_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            stream_q <= cmd_stream_len;
            flush_q  <= cmd_flush_len;
            clear_q  <= cmd_clear;
            step_q   <= 2'd0;
            err_q    <= ERR_OK;
            polls_q  <= '0;
          end
        end
        ST_WR_RESP: begin
          if (port_done) begin
            if (port_err) err_q  <= ERR_BRESP;
            else          step_q <= step_q + 2'd1;
          end
        end
        ST_RD_REQ: if (polls_q != 16'hFFFF) polls_q <= polls_q + 16'd1;
        ST_RD_DATA: begin
          if (port_done) begin
            if (port_err)                           err_q <= ERR_RRESP;
            else if (!status_done && poll_exhausted) err_q <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  axil_master_port #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) u_port (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .req          (port_req),
    .we           (port_we),
    .addr         (port_addr),
    .wdata        (port_wdata),
    .done         (port_done),
    .rdata        (port_rdata),
    .resp         (port_resp),
    .dbg_state    (dbg_port_state),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

endmodule
